// File: rtl/mult16_pkg.sv
// Shared geometry of the 16x16 partial-product bus: column widths, bases and bit indices.
// The pp generator and the compressor-side wrapper both slice the bus with these functions.
package mult16_pkg;

   localparam int N       = 16;
   localparam int NCOL    = 2*N - 1;
   localparam int PP_BITS = N*N;

   typedef logic [PP_BITS-1:0] pp_bus_t;

   typedef struct packed {
      logic [N-1:0] a;
      logic [N-1:0] b;
   } opnd_t;

   // Column k has one AND bit per (i,j) with i+j==k.
   function automatic int col_width(input int k);
      return (k < N) ? k + 1 : NCOL - k;
   endfunction

   // Lowest multiplicand bit index that lands in column k.
   function automatic int col_lo(input int k);
      return (k < N) ? 0 : k - (N - 1);
   endfunction

   function automatic int col_base(input int k);
      int base;
      base = 0;
      for (int m = 0; m < k; m++) base += col_width(m);
      return base;
   endfunction

   function automatic int pp_index(input int k, input int r);
      return col_base(k) + r;
   endfunction

endpackage

// File: rtl/mult16_pp_pack.sv
// Combinational AND array: every a[i]&b[j] placed into column i+j of the packed bus.
module mult16_pp_pack
   import mult16_pkg::*;
(
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output pp_bus_t      pp_o
);

   for (genvar k = 0; k < NCOL; k++) begin : g_col
      localparam int LO = col_lo(k);
      localparam int W  = col_width(k);
      for (genvar r = 0; r < W; r++) begin : g_bit
         assign pp_o[pp_index(k, r)] = a_i[r + LO] & b_i[k - r - LO];
      end
   end

endmodule

// File: rtl/mult16_pp_gen.sv
// Two-stage streaming partial-product generator with valid/ready backpressure,
// tag sideband and a wrapping output-handshake counter.
module mult16_pp_gen
   import mult16_pkg::*;
#(
   parameter int TAG_W = 8,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N-1:0]       in_a,
   input  logic [N-1:0]       in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PP_BITS-1:0] out_pp,
   output logic [TAG_W-1:0]   out_tag,
   output logic [CNT_W-1:0]   beat_cnt
);

   logic             s1_vld_q, s2_vld_q;
   opnd_t            s1_op_q;
   logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
   pp_bus_t          pp_d, pp_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             s2_adv, s1_adv, in_fire, out_fire;

   assign s2_adv   = !s2_vld_q || out_ready;
   assign s1_adv   = s2_adv || !s1_vld_q;
   assign in_ready = s1_adv;
   assign in_fire  = in_valid && s1_adv;
   assign out_fire = s2_vld_q && out_ready;

   mult16_pp_pack u_pack (
      .a_i  (s1_op_q.a),
      .b_i  (s1_op_q.b),
      .pp_o (pp_d)
   );

   always_comb begin
      cnt_d = cnt_q;
      if (out_fire) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q <= 1'b0;
         s2_vld_q <= 1'b0;
         pp_q     <= '0;
         s2_tag_q <= '0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (s1_adv) s1_vld_q <= in_valid;
         if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            // Only overwrite S2 data with a real beat so an idle output keeps its last value.
            if (s1_vld_q) begin
               pp_q     <= pp_d;
               s2_tag_q <= s1_tag_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         s1_op_q.a <= in_a;
         s1_op_q.b <= in_b;
         s1_tag_q  <= in_tag;
      end
   end

   assign out_valid = s2_vld_q;
   assign out_pp    = pp_q;
   assign out_tag   = s2_tag_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_mult16_pp_gen.sv
// Scoreboard bench for mult16_pp_gen: directed packing cases, stall, mid-stream reset,
// counter wrap (narrow-counter instance) and a random backpressure stream.
module tb_mult16_pp_gen;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready, in_ready_w;
   logic [15:0]  in_a = '0, in_b = '0;
   logic [7:0]   in_tag = '0;
   logic         out_valid, out_valid_w;
   logic         out_ready = 1'b0;
   logic [255:0] out_pp, out_pp_w;
   logic [7:0]   out_tag, out_tag_w;
   logic [31:0]  beat_cnt;
   logic [1:0]   beat_cnt_w;

   always #5 clk = ~clk;

   mult16_pp_gen #(.TAG_W(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_pp(out_pp), .out_tag(out_tag), .beat_cnt(beat_cnt)
   );

   mult16_pp_gen #(.TAG_W(8), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid_w),
      .out_ready(out_ready), .out_pp(out_pp_w), .out_tag(out_tag_w), .beat_cnt(beat_cnt_w)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  t;
   } beat_t;

   beat_t        sb[$];
   int           n_chk = 0, n_fail = 0, n_pop = 0;
   logic [255:0] last_pp;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Weighted column sum, walking the bus column by column with a running index.
   function automatic logic [31:0] colsum(input logic [255:0] pp);
      logic [31:0] s;
      int idx, w;
      s = '0;
      idx = 0;
      for (int k = 0; k < 31; k++) begin
         w = (k < 16) ? k + 1 : 31 - k;
         for (int r = 0; r < w; r++) begin
            if (pp[idx]) s += (32'd1 << k);
            idx++;
         end
      end
      return s;
   endfunction

   task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] t, input logic ordy, output logic acc);
      beat_t e;
      @(posedge clk);
      #1;
      in_valid = iv; in_a = a; in_b = b; in_tag = t; out_ready = ordy;
      @(negedge clk);
      acc = iv && in_ready;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 256'(1), 256'(0));
         else begin
            e = sb.pop_front();
            chk("product", 256'(colsum(out_pp)), 256'(32'(e.a) * 32'(e.b)));
            chk("tag", 256'(out_tag), 256'(e.t));
            last_pp = out_pp;
            n_pop++;
         end
      end
      if (acc) begin
         e.a = a; e.b = b; e.t = t;
         sb.push_back(e);
      end
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      cyc(1'b0, 16'h0, 16'h0, 8'h0, ordy, acc);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      sb.delete();
   endtask

   task automatic one_beat(input logic [15:0] a, input logic [15:0] b, input logic [7:0] t);
      logic acc;
      cyc(1'b1, a, b, t, 1'b1, acc);
      chk("one_acc", 256'(acc), 256'(1));
      repeat (3) idle(1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0 && !out_valid) break;
         idle(1'b1);
      end
      chk("drain_empty", 256'(sb.size()), 256'(0));
   endtask

   initial begin
      logic         acc;
      logic [255:0] hold;
      int           p0, nacc, guard;

      do_reset();
      chk("rst_ovalid", 256'(out_valid), 256'(0));
      chk("rst_iready", 256'(in_ready), 256'(1));
      chk("rst_cnt", 256'(beat_cnt), 256'(0));
      chk("rst_pp", out_pp, 256'(0));
      chk("rst_tag", 256'(out_tag), 256'(0));

      // All-ones operands: every AND bit set; checks 2-cycle latency too.
      cyc(1'b1, 16'hFFFF, 16'hFFFF, 8'h11, 1'b1, acc);
      chk("ff_acc", 256'(acc), 256'(1));
      idle(1'b1);
      chk("lat_n1", 256'(out_valid), 256'(0));
      p0 = n_pop;
      idle(1'b1);
      chk("lat_n2", 256'(out_valid), 256'(1));
      chk("ff_pop", 256'(n_pop - p0), 256'(1));
      chk("ff_pp", last_pp, {256{1'b1}});
      idle(1'b1);
      chk("ff_cnt", 256'(beat_cnt), 256'(1));

      one_beat(16'h0001, 16'h8000, 8'h22);
      chk("col15_pp", last_pp, 256'(1) << 120);
      one_beat(16'h8000, 16'h8000, 8'h33);
      chk("col30_pp", last_pp, 256'(1) << 255);
      chk("cnt3", 256'(beat_cnt), 256'(3));

      // Stall: three beats offered while downstream is blocked.
      p0 = n_pop;
      cyc(1'b1, 16'h1234, 16'h0042, 8'h40, 1'b0, acc);
      chk("stall_acc0", 256'(acc), 256'(1));
      cyc(1'b1, 16'hBEEF, 16'h0F0F, 8'h41, 1'b0, acc);
      chk("stall_acc1", 256'(acc), 256'(1));
      cyc(1'b1, 16'hA5A5, 16'h5A5A, 8'h42, 1'b0, acc);
      chk("stall_rej", 256'(acc), 256'(0));
      chk("stall_irdy", 256'(in_ready), 256'(0));
      hold = out_pp;
      cyc(1'b1, 16'hA5A5, 16'h5A5A, 8'h42, 1'b0, acc);
      chk("stall_rej2", 256'(acc), 256'(0));
      chk("stall_stable", out_pp, hold);
      chk("stall_ovalid", 256'(out_valid), 256'(1));
      cyc(1'b1, 16'hA5A5, 16'h5A5A, 8'h42, 1'b1, acc);
      chk("release_acc", 256'(acc), 256'(1));
      drain();
      chk("stall_pops", 256'(n_pop - p0), 256'(3));

      // Reset with two beats in flight.
      cyc(1'b1, 16'h7777, 16'h0003, 8'h50, 1'b0, acc);
      cyc(1'b1, 16'h0101, 16'h0202, 8'h51, 1'b0, acc);
      do_reset();
      chk("mrst_ovalid", 256'(out_valid), 256'(0));
      chk("mrst_iready", 256'(in_ready), 256'(1));
      chk("mrst_cnt", 256'(beat_cnt), 256'(0));
      p0 = n_pop;
      one_beat(16'd1234, 16'd5678, 8'h60);
      chk("mrst_pop", 256'(n_pop - p0), 256'(1));
      chk("mrst_pp_sum", 256'(colsum(last_pp)), 256'(32'd7006652));

      // Narrow counter instance wraps 3 -> 0.
      one_beat(16'h0003, 16'h0005, 8'h61);
      one_beat(16'hFFFF, 16'h0001, 8'h62);
      chk("wrap_pre", 256'(beat_cnt_w), 256'(3));
      one_beat(16'h0100, 16'h0100, 8'h63);
      chk("wrap_zero", 256'(beat_cnt_w), 256'(0));
      chk("wide_cnt4", 256'(beat_cnt), 256'(4));

      // Random stream with random valid/ready.
      do_reset();
      p0 = n_pop;
      nacc = 0;
      guard = 0;
      while (nacc < 1000 && guard < 20000) begin
         cyc(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 8'(nacc),
             ($urandom_range(0, 9) < 7), acc);
         if (acc) nacc++;
         guard++;
      end
      chk("rand_accepted", 256'(nacc), 256'(1000));
      drain();
      chk("rand_pops", 256'(n_pop - p0), 256'(1000));
      chk("rand_cnt", 256'(beat_cnt), 256'(1000));
      chk("rand_cnt_w", 256'(beat_cnt_w), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
